// File: rtl/seven_seg_scan.sv
// seven_seg_scan: multiplexed 4-digit seven-segment driver with per-frame snapshot,
// dead-time blanking, sign/overflow digit and optional leading-zero suppression.
module seven_seg_scan #(
   parameter int REFRESH_DIV = 12500,
   parameter int DEAD_CYC    = 64,
   parameter bit LZ_BLANK    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic        ovf,
   output logic [6:0]  seg,
   output logic [3:0]  anode,
   output logic        frame_tick
);
   localparam int CW = $clog2(REFRESH_DIV);
   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          first;
   logic [15:0]   snap;
   logic          snap_ovf;
   logic          term, cap, dead, lz_hide;
   logic [3:0]    nib;
   logic [6:0]    seg_n;
   logic [3:0]    anode_n;
   function automatic logic [6:0] num(input logic [3:0] d);
      case (d)
         4'd0: num = 7'h40;
         4'd1: num = 7'h79;
         4'd2: num = 7'h24;
         4'd3: num = 7'h30;
         4'd4: num = 7'h19;
         4'd5: num = 7'h12;
         4'd6: num = 7'h02;
         4'd7: num = 7'h78;
         4'd8: num = 7'h00;
         4'd9: num = 7'h10;
         default: num = 7'h7F;
      endcase
   endfunction
   // first is set by reset so the very first edge after release takes a snapshot
   always_comb begin
      term    = cnt == CW'(REFRESH_DIV - 1);
      cap     = first | (term & (idx == 2'd3));
      dead    = cnt < CW'(DEAD_CYC);
      nib     = snap[{idx, 2'b00} +: 4];
      lz_hide = LZ_BLANK && snap[11:8] == 4'd0 && (idx == 2'd2 || (idx == 2'd1 && snap[7:4] == 4'd0));
      seg_n   = dead ? 7'h7F :
                idx == 2'd3 ? (snap_ovf ? 7'h06 : nib == 4'hE ? 7'h3F : num(nib)) :
                lz_hide ? 7'h7F : num(nib);
      anode_n = dead ? 4'b1111 : ~(4'b0001 << idx);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         idx        <= 2'd0;
         first      <= 1'b1;
         snap       <= 16'hF000;
         snap_ovf   <= 1'b0;
         seg        <= 7'h7F;
         anode      <= 4'b1111;
         frame_tick <= 1'b0;
      end else begin
         cnt        <= term ? '0 : cnt + 1'b1;
         idx        <= term ? idx + 2'd1 : idx;
         first      <= 1'b0;
         frame_tick <= cap;
         snap       <= cap ? digits : snap;
         snap_ovf   <= cap ? ovf : snap_ovf;
         seg        <= seg_n;
         anode      <= anode_n;
      end
   end
endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed scan/decode checks of seven_seg_scan against a frame-level model,
// with two instances differing only in leading-zero suppression.
module tb_seven_seg_scan;
   localparam int DIV  = 8;
   localparam int DEAD = 2;
   localparam logic [6:0] TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   logic clk = 1'b0, reset = 1'b1, ovf = 1'b0, run = 1'b0;
   logic [15:0] digits = 16'hF579;
   logic [6:0] seg1, seg0;
   logic [3:0] an1, an0;
   logic ft1, ft0;
   int checks = 0, failures = 0;
   int n = 0;
   logic [15:0] msnap = 16'hF000;
   logic mov = 1'b0;
   logic [6:0] e_seg1 = 7'h7F, e_seg0 = 7'h7F;
   logic [3:0] e_an = 4'hF;
   logic e_ft = 1'b0;

   seven_seg_scan #(.REFRESH_DIV(DIV), .DEAD_CYC(DEAD), .LZ_BLANK(1'b1)) u1 (
      .clk(clk), .reset(reset), .digits(digits), .ovf(ovf), .seg(seg1), .anode(an1), .frame_tick(ft1));
   seven_seg_scan #(.REFRESH_DIV(DIV), .DEAD_CYC(DEAD), .LZ_BLANK(1'b0)) u0 (
      .clk(clk), .reset(reset), .digits(digits), .ovf(ovf), .seg(seg0), .anode(an0), .frame_tick(ft0));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t n=%0d: got %h expected %h", name, $time, n, got, exp);
      end
   endtask

   // p = scan position (clocks since release); the shown digit is chosen from the frame snapshot
   function automatic logic [6:0] model_seg(int p, logic [15:0] s, logic o, bit lz);
      int k, d;
      k = (p / DIV) % 4;
      d = (s >> (4 * k)) & 15;
      if (p % DIV < DEAD) return 7'h7F;
      if (k == 3) return o ? 7'h06 : d == 14 ? 7'h3F : d < 10 ? TAB[d] : 7'h7F;
      if (lz && s[11:8] == 4'd0 && (k == 2 || (k == 1 && d == 0))) return 7'h7F;
      return d < 10 ? TAB[d] : 7'h7F;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         n = 0; msnap = 16'hF000; mov = 1'b0;
         e_seg1 = 7'h7F; e_seg0 = 7'h7F; e_an = 4'hF; e_ft = 1'b0;
      end else begin
         n++;
         e_an   = ((n - 1) % DIV < DEAD) ? 4'hF : ~(4'b0001 << (((n - 1) / DIV) % 4));
         e_seg1 = model_seg(n - 1, msnap, mov, 1'b1);
         e_seg0 = model_seg(n - 1, msnap, mov, 1'b0);
         e_ft   = (n == 1) || (n % (4 * DIV) == 0);
         if (e_ft) begin msnap = digits; mov = ovf; end
      end
   end

   always @(negedge clk) if (run) begin
      chk("seg_lz1", {9'd0, seg1}, {9'd0, reset ? e_seg1 : 7'h7F});
      chk("seg_lz0", {9'd0, seg0}, {9'd0, reset ? e_seg0 : 7'h7F});
      chk("anode_lz1", {12'd0, an1}, {12'd0, reset ? e_an : 4'hF});
      chk("anode_lz0", {12'd0, an0}, {12'd0, reset ? e_an : 4'hF});
      chk("tick_lz1", {15'd0, ft1}, {15'd0, reset ? e_ft : 1'b0});
      chk("tick_lz0", {15'd0, ft0}, {15'd0, reset ? e_ft : 1'b0});
   end

   task automatic go(input int target);
      while (n < target) @(negedge clk);
   endtask

   task automatic lit(input string name, input logic [6:0] s1, input logic [6:0] s0, input logic [3:0] a);
      chk({name, "_seg1"}, {9'd0, seg1}, {9'd0, s1});
      chk({name, "_seg0"}, {9'd0, seg0}, {9'd0, s0});
      chk({name, "_an"}, {12'd0, an1}, {12'd0, a});
   endtask

   initial begin
      #1 reset = 1'b0;
      run = 1'b1;
      repeat (3) @(negedge clk);
      lit("rst", 7'h7F, 7'h7F, 4'hF);
      chk("rst_tick", {15'd0, ft1}, 16'd0);
      reset = 1'b1;
      go(1); chk("first_tick", {15'd0, ft1}, 16'd1);
      go(2); lit("dead0", 7'h7F, 7'h7F, 4'hF);
      go(3); lit("f579_ones", 7'h10, 7'h10, 4'hE);
      go(11); lit("f579_tens", 7'h78, 7'h78, 4'hD);
      go(19); lit("f579_hund", 7'h12, 7'h12, 4'hB);
      go(27); lit("f579_sign", 7'h7F, 7'h7F, 4'h7);
      go(30); digits = 16'hE400;
      go(32); chk("frame_tick", {15'd0, ft1}, 16'd1);
      go(33); chk("tick_clear", {15'd0, ft1}, 16'd0);
      go(35); lit("e400_ones", 7'h40, 7'h40, 4'hE);
      go(43); lit("e400_tens", 7'h40, 7'h40, 4'hD);
      go(51); lit("e400_hund", 7'h19, 7'h19, 4'hB);
      go(59); lit("e400_sign", 7'h3F, 7'h3F, 4'h7);
      go(60); digits = 16'hF007;
      go(67); lit("f007_ones", 7'h78, 7'h78, 4'hE);
      go(75); lit("f007_tens", 7'h7F, 7'h40, 4'hD);
      go(83); lit("f007_hund", 7'h7F, 7'h40, 4'hB);
      go(92); digits = 16'hF000; ovf = 1'b1;
      go(99); lit("f000_ones", 7'h40, 7'h40, 4'hE);
      go(105); digits = 16'hF123;
      go(107); lit("f000_tens", 7'h7F, 7'h40, 4'hD);
      go(115); lit("f000_hund", 7'h7F, 7'h40, 4'hB);
      go(123); lit("ovf_sign", 7'h06, 7'h06, 4'h7);
      go(131); lit("f123_ones", 7'h30, 7'h30, 4'hE);
      go(139); lit("f123_tens", 7'h24, 7'h24, 4'hD);
      go(147); lit("f123_hund", 7'h79, 7'h79, 4'hB);
      go(155); lit("f123_ovf", 7'h06, 7'h06, 4'h7);
      go(156); ovf = 1'b0;
      go(187); lit("f123_sign", 7'h7F, 7'h7F, 4'h7);
      go(212); lit("pre_rst", 7'h79, 7'h79, 4'hB);
      #2 reset = 1'b0;
      #1 lit("async_rst", 7'h7F, 7'h7F, 4'hF);
      chk("async_tick", {15'd0, ft1}, 16'd0);
      repeat (3) @(negedge clk);
      lit("held_rst", 7'h7F, 7'h7F, 4'hF);
      reset = 1'b1;
      go(1); chk("re_tick", {15'd0, ft1}, 16'd1);
      go(2); lit("re_dead", 7'h7F, 7'h7F, 4'hF);
      go(3); lit("re_ones", 7'h30, 7'h30, 4'hE);
      go(70);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
